uart_pkt_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_pkt_tx.sv | 148 ++++++++++++++
 tb/tb_uart_pkt_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the packet UART transmitter: state encoding,
// byte width and runtime length clamping.
package uart_tx_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } tx_state_t;

  // A zero or oversized request means "send the whole packet".
  function automatic int clamp_len(input int len, input int max_bytes);
    return (len == 0 || len > max_bytes) ? max_bytes : len;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time down-counter: bit_tick pulses for one cycle at count 0 and the
// count reloads to DIVISOR-1 whenever reload is high.
module uart_baud_gen #(
  parameter int DIVISOR = 4,
  localparam int CNT_W = $clog2(DIVISOR)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic reload,
  output logic bit_tick
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= CNT_W'(DIVISOR - 1);
    end else if (reload) begin
      cnt_q <= CNT_W'(DIVISOR - 1);
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_pkt_tx.sv
// Multi-byte UART packet transmitter with valid/ready handshake.
// Define TX_PARITY_EN to insert a parity bit after each byte's data bits.
module uart_pkt_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DIVISOR    = CLK_HZ / BAUD_RATE,
  parameter int PKT_BYTES  = 26,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0,
  parameter int PARITY_ODD = 0,
  localparam int DATA_W    = BITS_PER_BYTE * PKT_BYTES,
  localparam int LEN_W     = $clog2(PKT_BYTES + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] val_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              data_out
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] pkt_q;
  logic [LEN_W-1:0]  len_q, byte_q, byte_d, next_byte;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        aux_q, aux_d;
  logic [7:0]        shift_q, shift_d, next_val;
  logic              data_d, done_d, accept, tick, last_byte, par_bit, next_start;

  uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .reload  ((state_q == IDLE) || tick),
    .bit_tick(tick)
  );

  assign next_byte = byte_q + LEN_W'(1);
  assign last_byte = (byte_q == len_q - LEN_W'(1));
  assign next_val  = pkt_q[int'(next_byte) * BITS_PER_BYTE +: BITS_PER_BYTE];
  assign par_bit   = (^pkt_q[int'(byte_q) * BITS_PER_BYTE +: BITS_PER_BYTE]) ^ (PARITY_ODD != 0);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    aux_d      = aux_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    next_start = 1'b0;
    unique case (state_q)
      IDLE: if (valid_in) begin
        accept  = 1'b1;
        state_d = START;
        shift_d = val_in[7:0];
        byte_d  = '0;
        bit_d   = '0;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          aux_d = '0;
`ifdef TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        aux_d   = '0;
      end
      STOP: if (tick) begin
        if (aux_q != 8'(STOP_BITS - 1)) begin
          aux_d = aux_q + 8'd1;
        end else if (last_byte) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (GAP_BITS > 0) begin
          state_d = GAP;
          aux_d   = '0;
        end else begin
          next_start = 1'b1;
        end
      end
      GAP: if (tick) begin
        if (aux_q != 8'(GAP_BITS - 1)) aux_d = aux_q + 8'd1;
        else next_start = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (next_start) begin
      state_d = START;
      byte_d  = next_byte;
      bit_d   = '0;
      shift_d = next_val;
    end

    // The line level is registered, decoded from where the FSM is heading.
    unique case (state_d)
      START:   data_d = 1'b0;
      DATA:    data_d = shift_d[0];
      PARITY:  data_d = par_bit;
      default: data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      data_out <= 1'b1;
      done_out <= 1'b0;
      byte_q   <= '0;
      bit_q    <= '0;
      aux_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_out <= data_d;
      done_out <= done_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      aux_q    <= aux_d;
    end
  end

  // Packet payload is only meaningful once accepted, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      pkt_q <= val_in;
      len_q <= LEN_W'(clamp_len(int'(len_in), PKT_BYTES));
    end
    shift_q <= shift_d;
  end

  assign ready_out = (state_q == IDLE);
  assign busy_out  = !ready_out;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Bench for uart_pkt_tx: four instances (base, gap, two stop bits, odd parity)
// checked cycle by cycle against an expected serial waveform built per packet.
module tb_uart_pkt_tx;

  localparam int DIV = 4;
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR = (10 + PB) * DIV;
  localparam int STOP_C [4] = '{1, 1, 2, 1};
  localparam int GAP_C  [4] = '{0, 1, 0, 0};
  localparam int ODD_C  [4] = '{0, 0, 0, 1};

  logic        clk, rst, valid;
  logic [31:0] val;
  logic [2:0]  len;
  logic [3:0]  ready_o, busy_o, done_o, data_o;

  int checks = 0;
  int errors = 0;
  bit exp_q [4][$];
  int done_at [4];
  logic [3:0] samp;

  uart_pkt_tx #(.DIVISOR(DIV), .PKT_BYTES(4), .STOP_BITS(1), .GAP_BITS(0), .PARITY_ODD(0)) dut_b (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready_o[0]), .val_in(val),
    .len_in(len), .busy_out(busy_o[0]), .done_out(done_o[0]), .data_out(data_o[0]));
  uart_pkt_tx #(.DIVISOR(DIV), .PKT_BYTES(4), .STOP_BITS(1), .GAP_BITS(1), .PARITY_ODD(0)) dut_g (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready_o[1]), .val_in(val),
    .len_in(len), .busy_out(busy_o[1]), .done_out(done_o[1]), .data_out(data_o[1]));
  uart_pkt_tx #(.DIVISOR(DIV), .PKT_BYTES(4), .STOP_BITS(2), .GAP_BITS(0), .PARITY_ODD(0)) dut_s (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready_o[2]), .val_in(val),
    .len_in(len), .busy_out(busy_o[2]), .done_out(done_o[2]), .data_out(data_o[2]));
  uart_pkt_tx #(.DIVISOR(DIV), .PKT_BYTES(4), .STOP_BITS(1), .GAP_BITS(0), .PARITY_ODD(1)) dut_o (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready_o[3]), .val_in(val),
    .len_in(len), .busy_out(busy_o[3]), .done_out(done_o[3]), .data_out(data_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          len;
    int          n;
    int          done_base;
    int          done_gap;
    int          done_stop;
    bit          disturb;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic put(input int c, input bit b);
    repeat (DIV) exp_q[c].push_back(b);
  endtask

  // Expected line level per cycle after acceptance, straight from the frame format.
  task automatic build(input int c, input logic [31:0] v, input int l);
    int n;
    logic [7:0] by;
    n = (l == 0 || l > 4) ? 4 : l;
    exp_q[c].delete();
    for (int b = 0; b < n; b++) begin
      by = v[8*b +: 8];
      put(c, 1'b0);
      for (int i = 0; i < 8; i++) put(c, by[i]);
      if (PB != 0) put(c, (^by) ^ (ODD_C[c] != 0));
      for (int s = 0; s < STOP_C[c]; s++) put(c, 1'b1);
      if (b < n - 1) for (int g = 0; g < GAP_C[c]; g++) put(c, 1'b1);
    end
  endtask

  task automatic run_packet(input logic [31:0] v, input int l, input bit disturb);
    int maxd;
    maxd = 0;
    for (int c = 0; c < 4; c++) begin
      build(c, v, l);
      done_at[c] = -1;
      if (exp_q[c].size() > maxd) maxd = exp_q[c].size();
    end
    @(negedge clk);
    valid = 1'b1;
    val   = v;
    len   = 3'(l);
    @(posedge clk);
    for (int k = 1; k <= maxd + 4; k++) begin
      @(negedge clk);
      if (k == 38) samp = data_o;
      for (int c = 0; c < 4; c++) begin
        if (done_o[c] === 1'b1 && done_at[c] < 0) done_at[c] = k;
        if (k <= exp_q[c].size()) begin
          chk($sformatf("line dut%0d cyc%0d", c, k), data_o[c], exp_q[c][k-1]);
          chk($sformatf("ready dut%0d cyc%0d", c, k), ready_o[c], 1'b0);
          chk($sformatf("done dut%0d cyc%0d", c, k), done_o[c], 1'b0);
        end else if (k == exp_q[c].size() + 1) begin
          chk($sformatf("end_line dut%0d", c), data_o[c], 1'b1);
          chk($sformatf("end_ready dut%0d", c), ready_o[c], 1'b1);
          chk($sformatf("end_busy dut%0d", c), busy_o[c], 1'b0);
          chk($sformatf("end_done dut%0d", c), done_o[c], 1'b1);
        end else begin
          chk($sformatf("idle_line dut%0d cyc%0d", c, k), data_o[c], 1'b1);
          chk($sformatf("idle_done dut%0d cyc%0d", c, k), done_o[c], 1'b0);
        end
      end
      if (k == 1) begin
        valid = 1'b0;
        val   = $urandom;
        len   = 3'($urandom_range(0, 7));
      end
      if (disturb && k == 9) begin
        valid = 1'b1;
        val   = ~v;
      end
      if (disturb && k == 10) valid = 1'b0;
    end
  endtask

  vec_t tbl [5];
  int d1, d2, nb;
  logic l_hi, l_lo;
  logic [31:0] rv;
  int rl;
  bit idle_ok;

  initial begin
    rst = 1'b1; valid = 1'b0; val = '0; len = '0;
    tbl[0] = '{32'h0000_00A5, 1, 1, 41, 41, 45, 1'b0};
    tbl[1] = '{32'h0403_0201, 0, 4, 161, 173, 177, 1'b1};
    tbl[2] = '{32'h00C3_7E11, 3, 3, 121, 129, 133, 1'b0};
    tbl[3] = '{32'hDEAD_BEEF, 5, 4, 161, 173, 177, 1'b1};
    tbl[4] = '{32'h0000_0007, 1, 1, 41, 41, 45, 1'b0};

    // Reset state, with valid_in asserted to show it is ignored.
    repeat (2) @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    chk_int("rst_line", int'(data_o), 15);
    chk_int("rst_ready", int'(ready_o), 15);
    chk_int("rst_busy", int'(busy_o), 0);
    chk_int("rst_done", int'(done_o), 0);
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_int("post_rst_ready", int'(ready_o), 15);

    for (int t = 0; t < 5; t++) begin
      run_packet(tbl[t].val, tbl[t].len, tbl[t].disturb);
      nb = PB * tbl[t].n * DIV;
      chk_int($sformatf("done_cyc base v%0d", t), done_at[0], tbl[t].done_base + nb);
      chk_int($sformatf("done_cyc gap v%0d", t), done_at[1], tbl[t].done_gap + nb);
      chk_int($sformatf("done_cyc stop2 v%0d", t), done_at[2], tbl[t].done_stop + nb);
      chk_int($sformatf("done_cyc odd v%0d", t), done_at[3], tbl[t].done_base + nb);
      if (t == 0) begin
`ifdef TX_PARITY_EN
        chk("par_even_A5", samp[0], 1'b0);
        chk("par_odd_A5", samp[3], 1'b1);
`else
        chk("stop_A5", samp[0], 1'b1);
        chk("stop_odd_A5", samp[3], 1'b1);
`endif
      end
      if (t == 4) begin
`ifdef TX_PARITY_EN
        chk("par_even_07", samp[0], 1'b1);
        chk("par_odd_07", samp[3], 1'b0);
`else
        chk("stop_07", samp[0], 1'b1);
        chk("stop_odd_07", samp[3], 1'b1);
`endif
      end
    end

    // Reset in the middle of a low data bit.
    @(negedge clk);
    valid = 1'b1; val = 32'h0; len = 3'd1;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
    end
    chk("pre_rst_line", data_o[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_int("async_rst_line", int'(data_o), 15);
    chk_int("async_rst_ready", int'(ready_o), 15);
    chk_int("async_rst_busy", int'(busy_o), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_int($sformatf("in_rst_done %0d", k), int'(done_o), 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk_int($sformatf("after_rst_done %0d", k), int'(done_o), 0);
      chk_int($sformatf("after_rst_line %0d", k), int'(data_o), 15);
    end
    run_packet(32'h0000_003C, 1, 1'b0);

    // Back-to-back packets with valid_in held high.
    @(negedge clk);
    valid = 1'b1; val = 32'h0000_00A5; len = 3'd1;
    d1 = -1; d2 = -1; l_hi = 1'bx; l_lo = 1'bx;
    @(posedge clk);
    for (int k = 1; k <= 2 * FR + 6; k++) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == FR + 1) l_hi = data_o[0];
      if (k == FR + 2) begin
        l_lo  = data_o[0];
        valid = 1'b0;
      end
    end
    chk_int("b2b_first_done", d1, FR + 1);
    chk_int("b2b_done_spacing", d2 - d1, FR + 1);
    chk("b2b_gap_line", l_hi, 1'b1);
    chk("b2b_second_start", l_lo, 1'b0);

    idle_ok = 1'b0;
    for (int k = 0; k < 300 && !idle_ok; k++) begin
      @(negedge clk);
      if (ready_o == 4'hF) idle_ok = 1'b1;
    end
    chk("b2b_all_idle", idle_ok, 1'b1);

    // Random packets against the waveform model.
    for (int r = 0; r < 8; r++) begin
      rv = $urandom;
      rl = $urandom_range(0, 7);
      run_packet(rv, rl, r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
